// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: time-slices a shared hex decoder across DIGITS
// common-anode digits with anti-ghosting gaps and tear-free frame-boundary updates.
// Optional leading-zero suppression is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl #(
    parameter int DIGITS  = 4,
    parameter int DIV     = 50000,
    parameter int GAP_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic [3:0]            nib,
    output logic [DIGITS-1:0]     an,
    output logic                  blank,
    output logic                  pend,
    output logic                  commit
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW = $clog2(DIV + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic {
        GAP   = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t                 state_reg,  state_next;
    logic [IW-1:0]          idx_reg,    idx_next;
    logic [DW-1:0]          div_reg,    div_next;
    logic [GW-1:0]          gap_reg,    gap_next;
    logic [4*DIGITS-1:0]    disp_reg,   disp_next;
    logic [4*DIGITS-1:0]    pbuf_reg,   pbuf_next;
    logic                   pend_reg,   pend_next;
    logic                   commit_reg, commit_next;
    logic [DIGITS-1:0]      an_reg,     an_next;
    logic [3:0]             nib_reg,    nib_next;
    logic                   blank_reg,  blank_next;
    logic                   frame_end;

    logic [DIGITS-1:0]      sel_next;
    logic [DIGITS-1:0]      lz_blank;

    genvar gi;

    // One-hot digit select for the upcoming cycle.
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_sel
            assign sel_next[gi] = (idx_next == IW'(gi));
        end
    endgenerate

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Digit i>0 is a leading zero when it and every higher displayed digit are zero.
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_lz
            if (gi == 0) begin : g_d0
                assign lz_blank[gi] = 1'b0;
            end else begin : g_dn
                assign lz_blank[gi] = (disp_next[4*DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        div_next    = div_reg;
        gap_next    = gap_reg;
        disp_next   = disp_reg;
        pbuf_next   = pbuf_reg;
        pend_next   = pend_reg;
        commit_next = 1'b0;
        frame_end   = 1'b0;

        case (state_reg)
            GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = DRIVE;
                    div_next   = '0;
                    frame_end  = (idx_reg == IDX_LAST);
                    idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end
            DRIVE: begin
                if (div_reg == DIV_LAST) begin
                    state_next = GAP;
                    gap_next   = '0;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            default: state_next = GAP;
        endcase

        // Displayed data only changes at the frame boundary, so a frame never tears.
        if (frame_end && pend_reg) begin
            disp_next   = pbuf_reg;
            pend_next   = 1'b0;
            commit_next = 1'b1;
        end

        // A load on the boundary cycle commits the old data and re-arms pend with the new.
        if (load) begin
            pbuf_next = value;
            pend_next = 1'b1;
        end
    end

    always_comb begin
        an_next    = '1;
        nib_next   = 4'h0;
        blank_next = 1'b1;
        if (state_next == DRIVE) begin
            an_next    = ~sel_next;
            nib_next   = disp_next[{idx_next, 2'b00} +: 4];
            blank_next = blank_mask[idx_next] | lz_blank[idx_next];
        end
    end

    // Outputs are registered from next-state values so they align with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= GAP;
            idx_reg    <= IDX_LAST;
            div_reg    <= '0;
            gap_reg    <= '0;
            disp_reg   <= '0;
            pbuf_reg   <= '0;
            pend_reg   <= 1'b0;
            commit_reg <= 1'b0;
            an_reg     <= '1;
            nib_reg    <= 4'h0;
            blank_reg  <= 1'b1;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            div_reg    <= div_next;
            gap_reg    <= gap_next;
            disp_reg   <= disp_next;
            pbuf_reg   <= pbuf_next;
            pend_reg   <= pend_next;
            commit_reg <= commit_next;
            an_reg     <= an_next;
            nib_reg    <= nib_next;
            blank_reg  <= blank_next;
        end
    end

    assign an     = an_reg;
    assign nib    = nib_reg;
    assign blank  = blank_reg;
    assign pend   = pend_reg;
    assign commit = commit_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with DIGITS=4, DIV=4, GAP_CYC=1 (20-cycle frame).
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic [3:0]  nib;
    logic [3:0]  an;
    logic        blank;
    logic        pend;
    logic        commit;

    int checks;
    int errors;
    int n;

    seg7_scan_ctrl #(
        .DIGITS  (4),
        .DIV     (4),
        .GAP_CYC (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .nib        (nib),
        .an         (an),
        .blank      (blank),
        .pend       (pend),
        .commit     (commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // n counts cycles since rst release; slot k*5 is a gap, k*5+1..k*5+4 drive digit k.
    function automatic logic [3:0] exp_an(int k);
        int p = k % 20;
        if (p % 5 == 0) return 4'hF;
        return ~(4'b0001 << (p / 5));
    endfunction

    function automatic logic [3:0] exp_nib(int k, logic [15:0] d);
        int p = k % 20;
        logic [15:0] sh;
        if (p % 5 == 0) return 4'h0;
        sh = d >> (4 * (p / 5));
        return sh[3:0];
    endfunction

    function automatic logic exp_blank(int k, logic [15:0] d, logic [3:0] m);
        int p = k % 20;
        int s;
        logic b;
        if (p % 5 == 0) return 1'b1;
        s = p / 5;
        b = m[s];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (s > 0 && (d >> (4 * s)) == 16'h0) b = 1'b1;
`endif
        return b;
    endfunction

    task automatic tick();
        @(negedge clk);
        n = n + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; value = 16'h0; blank_mask = 4'h0;
        repeat (2) @(negedge clk);
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got=%b exp=1111", an); end
        checks++; if (nib !== 4'h0) begin errors++; $display("FAIL reset_nib got=%h exp=0", nib); end
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank got=%b exp=1", blank); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL reset_pend got=%b exp=0", pend); end
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL reset_commit got=%b exp=0", commit); end
        $display("reset: an=%b nib=%h blank=%b pend=%b commit=%b", an, nib, blank, pend, commit);
        rst = 1'b0;
        n = 0;
    endtask

    task automatic test_scan_timing();
        while (n < 40) begin
            checks++; if (an !== exp_an(n)) begin errors++; $display("FAIL scan_an n=%0d got=%b exp=%b", n, an, exp_an(n)); end
            checks++; if (nib !== 4'h0) begin errors++; $display("FAIL scan_nib n=%0d got=%h exp=0", n, nib); end
            checks++; if (blank !== exp_blank(n, 16'h0, 4'h0)) begin errors++; $display("FAIL scan_blank n=%0d got=%b exp=%b", n, blank, exp_blank(n, 16'h0, 4'h0)); end
            checks++; if (pend !== 1'b0) begin errors++; $display("FAIL scan_pend n=%0d got=%b exp=0", n, pend); end
            checks++; if (commit !== 1'b0) begin errors++; $display("FAIL scan_commit n=%0d got=%b exp=0", n, commit); end
            tick();
        end
        $display("scan_timing: cycles 0..39 checked");
    endtask

    task automatic test_load_mid_frame();
        logic [15:0] d;
        while (n < 81) begin
            d = (n >= 61) ? 16'h1234 : 16'h0000;
            checks++; if (an !== exp_an(n)) begin errors++; $display("FAIL mid_an n=%0d got=%b exp=%b", n, an, exp_an(n)); end
            checks++; if (nib !== exp_nib(n, d)) begin errors++; $display("FAIL mid_nib n=%0d got=%h exp=%h", n, nib, exp_nib(n, d)); end
            checks++; if (pend !== (n >= 46 && n <= 60)) begin errors++; $display("FAIL mid_pend n=%0d got=%b", n, pend); end
            checks++; if (commit !== (n == 61)) begin errors++; $display("FAIL mid_commit n=%0d got=%b", n, commit); end
            load = (n == 45); value = 16'h1234;
            tick();
        end
        load = 1'b0;
        $display("load_mid_frame: load 1234 at cycle 45, commit expected at 61");
    endtask

    task automatic test_latest_wins();
        logic [15:0] d;
        while (n < 120) begin
            d = (n >= 101) ? 16'h2222 : 16'h1234;
            checks++; if (nib !== exp_nib(n, d)) begin errors++; $display("FAIL latest_nib n=%0d got=%h exp=%h", n, nib, exp_nib(n, d)); end
            checks++; if (pend !== (n >= 86 && n <= 100)) begin errors++; $display("FAIL latest_pend n=%0d got=%b", n, pend); end
            checks++; if (commit !== (n == 101)) begin errors++; $display("FAIL latest_commit n=%0d got=%b", n, commit); end
            load = (n == 85 || n == 90);
            value = (n == 85) ? 16'h1111 : 16'h2222;
            tick();
        end
        load = 1'b0;
        $display("latest_wins: loads 1111 then 2222 in one frame, single commit at 101");
    endtask

    task automatic test_boundary_load();
        logic [15:0] d;
        while (n < 181) begin
            d = (n >= 161) ? 16'hABCD : (n >= 141) ? 16'h1234 : 16'h2222;
            checks++; if (an !== exp_an(n)) begin errors++; $display("FAIL bnd_an n=%0d got=%b exp=%b", n, an, exp_an(n)); end
            checks++; if (nib !== exp_nib(n, d)) begin errors++; $display("FAIL bnd_nib n=%0d got=%h exp=%h", n, nib, exp_nib(n, d)); end
            checks++; if (pend !== (n >= 126 && n <= 160)) begin errors++; $display("FAIL bnd_pend n=%0d got=%b", n, pend); end
            checks++; if (commit !== (n == 141 || n == 161)) begin errors++; $display("FAIL bnd_commit n=%0d got=%b", n, commit); end
            load = (n == 125 || n == 140);
            value = (n == 140) ? 16'hABCD : 16'h1234;
            tick();
        end
        load = 1'b0;
        $display("boundary_load: ABCD loaded on boundary cycle 140 while 1234 pending");
    endtask

    task automatic test_mid_reset();
        while (n < 188) begin
            checks++; if (pend !== (n >= 186)) begin errors++; $display("FAIL mrst_pre_pend n=%0d got=%b", n, pend); end
            load = (n == 185); value = 16'h5555;
            if (n < 187) tick();
            else n = n + 1;
        end
        load = 1'b0;
        rst = 1'b1; blank_mask = 4'b0101;
        @(negedge clk);
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL mrst_an got=%b exp=1111", an); end
        checks++; if (nib !== 4'h0) begin errors++; $display("FAIL mrst_nib got=%h exp=0", nib); end
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL mrst_blank got=%b exp=1", blank); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL mrst_pend got=%b exp=0", pend); end
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL mrst_commit got=%b exp=0", commit); end
        rst = 1'b0;
        n = 0;
        while (n < 40) begin
            checks++; if (an !== exp_an(n)) begin errors++; $display("FAIL restart_an n=%0d got=%b exp=%b", n, an, exp_an(n)); end
            checks++; if (nib !== 4'h0) begin errors++; $display("FAIL restart_nib n=%0d got=%h exp=0", n, nib); end
            checks++; if (blank !== exp_blank(n, 16'h0, 4'b0101)) begin errors++; $display("FAIL restart_blank n=%0d got=%b exp=%b", n, blank, exp_blank(n, 16'h0, 4'b0101)); end
            checks++; if (pend !== 1'b0 || commit !== 1'b0) begin errors++; $display("FAIL restart_pend_commit n=%0d pend=%b commit=%b exp 0/0", n, pend, commit); end
            tick();
        end
        $display("mid_reset: reset during DRIVE with pend=1, restart with blank_mask=0101");
    endtask

    task automatic test_leading_zero();
        logic [15:0] d;
        blank_mask = 4'h0;
        while (n < 81) begin
            d = (n >= 61) ? 16'h0042 : 16'h0000;
            checks++; if (nib !== exp_nib(n, d)) begin errors++; $display("FAIL lz_nib n=%0d got=%h exp=%h", n, nib, exp_nib(n, d)); end
            checks++; if (blank !== exp_blank(n, d, 4'h0)) begin errors++; $display("FAIL lz_blank n=%0d got=%b exp=%b", n, blank, exp_blank(n, d, 4'h0)); end
            checks++; if (commit !== (n == 61)) begin errors++; $display("FAIL lz_commit n=%0d got=%b", n, commit); end
            load = (n == 45); value = 16'h0042;
            tick();
        end
        load = 1'b0;
        $display("leading_zero: value 0042 displayed from cycle 61");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n = 0;
        test_reset();
        test_scan_timing();
        test_load_mid_frame();
        test_latest_wins();
        test_boundary_load();
        test_mid_reset();
        test_leading_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter DIV, default 50000, clock cycles per digit drive period (>=2).
REQ-003 SHALL have parameter GAP_CYC, default 2, anti-ghosting all-off cycles between digits (>=1).
REQ-004 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port load  input  1  one-cycle strobe capturing value into pending buffer.
REQ-007 SHALL have port value  input  4*DIGITS  hex digits, digit 0 in bits [3:0], most significant digit at top.
REQ-008 SHALL have port blank_mask  input  DIGITS  bit i=1 forces digit i blank.
REQ-009 SHALL have port nib  output  4  hex nibble for the shared 7-segment decoder.
REQ-010 SHALL have port an  output  DIGITS  active-low digit enables.
REQ-011 SHALL have port blank  output  1  1 = downstream forces all segments off.
REQ-012 SHALL have port pend  output  1  pending buffer holds uncommitted data.
REQ-013 SHALL have port commit  output  1  one-cycle pulse when pending data becomes displayed.

Function
REQ-014 SHALL implement FSM {GAP, DRIVE} with digit index idx (0..DIGITS-1), divider counter and gap counter.
REQ-015 GAP SHALL last exactly GAP_CYC cycles, then advance idx (DIGITS-1 wraps to 0) and enter DRIVE with divider cleared.
REQ-016 DRIVE SHALL last exactly DIV cycles, then enter GAP with gap counter cleared.
REQ-017 In DRIVE, an SHALL be all ones except bit idx = 0; in GAP, an SHALL be all ones.
REQ-018 In DRIVE, nib SHALL equal displayed-register digit idx; in GAP, nib SHALL be 0 and blank SHALL be 1.
REQ-019 In DRIVE, blank SHALL equal blank_mask[idx] (plus REQ-029 term when enabled).
REQ-020 an, nib, blank SHALL be decoded from registered state only; no combinational path from load/value.
REQ-021 load SHALL copy value into pending buffer and set pend next cycle; a later load before commit SHALL overwrite (latest wins).
REQ-022 Frame boundary = GAP end with idx=DIGITS-1; if pend=1 there, displayed register SHALL take pending buffer, pend SHALL clear and commit SHALL pulse for that one cycle.
REQ-023 load on the frame-boundary cycle: old pending data SHALL commit; new value SHALL become pending with pend=1 afterward.
REQ-024 Displayed data SHALL never change mid-frame (no tearing).

Reset
REQ-025 On rst: state=GAP, gap counter=0, divider=0, idx=DIGITS-1, displayed register=0, pending buffer=0, pend=0, commit=0.
REQ-026 While in/after reset: an=all ones, nib=0, blank=1; first DRIVE (idx 0) SHALL start GAP_CYC cycles after rst deasserts.
REQ-027 rst asserted mid-operation SHALL take effect on the next edge, discarding pending data without a commit pulse.

Configuration
REQ-028 Macro SEG7_LEADING_ZERO_BLANK_EN SHALL select leading-zero suppression.
REQ-029 With macro defined: digit i>0 SHALL be blank when it and all higher displayed digits are 0; digit 0 never suppressed.
REQ-030 Without macro: blank in DRIVE SHALL depend only on blank_mask.

Verification (DIGITS=4, DIV=4, GAP_CYC=1)
REQ-031 Release rst -> an=1111 1 cycle, an=1110 nib=0 4 cycles, an=1111 1 cycle, an=1101 4 cycles; frame period 20 cycles.
REQ-032 load 16'h1234 mid-frame -> pend=1, nib stays 0 until frame end; commit pulse at frame boundary; then nib 4,3,2,1 on an 1110,1101,1011,0111.
REQ-033 load 16'h1111 then 16'h2222 within one frame -> exactly one commit, all digits show 2.
REQ-034 load 16'hABCD on frame-boundary cycle while 16'h1234 pending -> commit, frame shows 1234, pend=1, next boundary commits ABCD.
REQ-035 Macro defined, value 16'h0042 -> digits 3,2 blank=1, digit 1 nib=4 blank=0, digit 0 nib=2; value 0 -> only digit 0 unblanked; macro undefined -> blank=0 throughout DRIVE.
REQ-036 rst pulse mid-DRIVE with pend=1 -> next cycle an=1111, blank=1, pend=0, no commit; restart per REQ-031.
